// File: rtl/blockram_pkg.sv
// Shared types and helpers for the true dual-port block RAM: write-mode and
// clear-sequencer enums plus the byte-lane count derived from the word width.
package blockram_pkg;

  typedef enum logic [1:0] {
    READ_FIRST  = 2'd0,
    WRITE_FIRST = 2'd1,
    NO_CHANGE   = 2'd2
  } write_mode_t;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } clear_state_t;

  function automatic int unsigned byte_lanes(input int unsigned width);
    return width / 32'd8;
  endfunction

endpackage

// File: rtl/blockram_true_dual_port_if.sv
// Port bundle for the true dual-port block RAM: two independent request ports
// plus the shared collision and busy status lines.
interface blockram_true_dual_port_if #(
  parameter int unsigned RAM_WIDTH = 32'd16,
  parameter int unsigned RAM_DEPTH = 32'd1024
);
  import blockram_pkg::*;

  localparam int unsigned LANES  = byte_lanes(RAM_WIDTH);
  localparam int unsigned ADDR_W = $clog2(RAM_DEPTH);

  logic                 write_enable_A;
  logic                 read_enable_A;
  logic [LANES-1:0]     byte_enable_A;
  logic [ADDR_W-1:0]    address_A;
  logic [RAM_WIDTH-1:0] data_in_A;
  logic [RAM_WIDTH-1:0] data_out_A;
  logic                 valid_A;

  logic                 write_enable_B;
  logic                 read_enable_B;
  logic [LANES-1:0]     byte_enable_B;
  logic [ADDR_W-1:0]    address_B;
  logic [RAM_WIDTH-1:0] data_in_B;
  logic [RAM_WIDTH-1:0] data_out_B;
  logic                 valid_B;

  logic                 collision;
  logic                 busy;

  modport master (
    output write_enable_A, read_enable_A, byte_enable_A, address_A, data_in_A,
    output write_enable_B, read_enable_B, byte_enable_B, address_B, data_in_B,
    input  data_out_A, valid_A, data_out_B, valid_B, collision, busy
  );

  modport slave (
    input  write_enable_A, read_enable_A, byte_enable_A, address_A, data_in_A,
    input  write_enable_B, read_enable_B, byte_enable_B, address_B, data_in_B,
    output data_out_A, valid_A, data_out_B, valid_B, collision, busy
  );

endinterface

// File: rtl/blockram_out_pipe.sv
// Read-side output register chain: one or two data/valid stages. Data only
// advances alongside a valid flag, so the output holds between responses.
module blockram_out_pipe #(
  parameter int unsigned WIDTH   = 32'd16,
  parameter int unsigned LATENCY = 32'd1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out
);

  logic [WIDTH-1:0] data1_r;
  logic             valid1_r;

  // First stage: capture the response on the edge the request is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      data1_r  <= {WIDTH{1'b0}};
      valid1_r <= 1'b0;
    end else begin
      valid1_r <= load;
      if (load) begin
        data1_r <= data_in;
      end
    end
  end

  generate
    if (LATENCY == 32'd2) begin : g_two_stage
      logic [WIDTH-1:0] data2_r;
      logic             valid2_r;

      // Second stage: plain delay of the first, keeping one request per cycle.
      always_ff @(posedge clk) begin
        if (rst) begin
          data2_r  <= {WIDTH{1'b0}};
          valid2_r <= 1'b0;
        end else begin
          valid2_r <= valid1_r;
          if (valid1_r) begin
            data2_r <= data1_r;
          end
        end
      end

      assign data_out  = data2_r;
      assign valid_out = valid2_r;
    end else begin : g_one_stage
      assign data_out  = data1_r;
      assign valid_out = valid1_r;
    end
  endgenerate

endmodule

// File: rtl/blockram_true_dual_port.sv
// True dual-port block RAM with per-byte writes, per-port write modes, a 1- or
// 2-stage read pipeline and an optional array clear sweep after reset.
module blockram_true_dual_port
  import blockram_pkg::*;
#(
  parameter int unsigned RAM_WIDTH    = 32'd16,
  parameter int unsigned RAM_DEPTH    = 32'd1024,
  parameter int unsigned READ_LATENCY = 32'd1,
  parameter write_mode_t WRITE_MODE_A = READ_FIRST,
  parameter write_mode_t WRITE_MODE_B = READ_FIRST,
  parameter bit          INIT_CLEAR   = 1'b1
) (
  input logic                      clk,
  input logic                      rst,
  blockram_true_dual_port_if.slave bus
);

  localparam int unsigned       LANES     = byte_lanes(RAM_WIDTH);
  localparam int unsigned       ADDR_W    = $clog2(RAM_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 32'd1);

  logic [RAM_WIDTH-1:0] mem_r [RAM_DEPTH];

  clear_state_t         state_r;
  logic [ADDR_W-1:0]    clear_addr_r;
  logic                 busy_r;

  logic                 accept_s;
  logic [RAM_WIDTH-1:0] old_a_s, old_b_s;
  logic [RAM_WIDTH-1:0] rd_a_s, rd_b_s;
  logic                 ld_a_s, ld_b_s;
  logic                 coll_s;
  logic [RAM_WIDTH-1:0] pipe_data_a_s, pipe_data_b_s;
  logic                 pipe_valid_a_s, pipe_valid_b_s;
  logic                 coll_data_s, coll_valid_s;

  function automatic logic [RAM_WIDTH-1:0] merge_lanes(
    input logic [RAM_WIDTH-1:0] old_word,
    input logic [RAM_WIDTH-1:0] new_word,
    input logic [LANES-1:0]     lanes
  );
    logic [RAM_WIDTH-1:0] result;
    for (int unsigned i = 32'd0; i < LANES; i++) begin
      result[i*8 +: 8] = lanes[i] ? new_word[i*8 +: 8] : old_word[i*8 +: 8];
    end
    return result;
  endfunction

  // Clear sequencer: sweeps every address once after reset, then hands the array to the ports.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= INIT_CLEAR ? CLEAR : READY;
      clear_addr_r <= {ADDR_W{1'b0}};
      busy_r       <= INIT_CLEAR;
    end else begin
      case (state_r)
        CLEAR: begin
          if (clear_addr_r == LAST_ADDR) begin
            state_r <= READY;
            busy_r  <= 1'b0;
          end else begin
            clear_addr_r <= clear_addr_r + ADDR_W'(1'b1);
          end
        end
        READY: begin
          busy_r <= 1'b0;
        end
        default: begin
          state_r <= READY;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Response selection: cross-port readers always see the pre-edge word.
  always_comb begin
    accept_s = !rst && !busy_r;
    old_a_s  = mem_r[bus.address_A];
    old_b_s  = mem_r[bus.address_B];

    if (bus.write_enable_A && (WRITE_MODE_A == WRITE_FIRST)) begin
      rd_a_s = merge_lanes(old_a_s, bus.data_in_A, bus.byte_enable_A);
    end else begin
      rd_a_s = old_a_s;
    end
    if (bus.write_enable_B && (WRITE_MODE_B == WRITE_FIRST)) begin
      rd_b_s = merge_lanes(old_b_s, bus.data_in_B, bus.byte_enable_B);
    end else begin
      rd_b_s = old_b_s;
    end

    ld_a_s = accept_s && (bus.read_enable_A || bus.write_enable_A)
             && !(bus.write_enable_A && (WRITE_MODE_A == NO_CHANGE));
    ld_b_s = accept_s && (bus.read_enable_B || bus.write_enable_B)
             && !(bus.write_enable_B && (WRITE_MODE_B == NO_CHANGE));
    coll_s = accept_s && bus.write_enable_A && bus.write_enable_B
             && (bus.address_A == bus.address_B);
  end

  // Array update: port A lanes are applied after port B so A wins overlapping lanes.
  always_ff @(posedge clk) begin
    if (!rst && busy_r) begin
      mem_r[clear_addr_r] <= {RAM_WIDTH{1'b0}};
    end else if (accept_s) begin
      for (int unsigned i = 32'd0; i < LANES; i++) begin
        if (bus.write_enable_B && bus.byte_enable_B[i]) begin
          mem_r[bus.address_B][i*8 +: 8] <= bus.data_in_B[i*8 +: 8];
        end
      end
      for (int unsigned i = 32'd0; i < LANES; i++) begin
        if (bus.write_enable_A && bus.byte_enable_A[i]) begin
          mem_r[bus.address_A][i*8 +: 8] <= bus.data_in_A[i*8 +: 8];
        end
      end
    end
  end

  blockram_out_pipe #(.WIDTH(RAM_WIDTH), .LATENCY(READ_LATENCY)) u_pipe_a (
    .clk       (clk),
    .rst       (rst),
    .load      (ld_a_s),
    .data_in   (rd_a_s),
    .data_out  (pipe_data_a_s),
    .valid_out (pipe_valid_a_s)
  );

  blockram_out_pipe #(.WIDTH(RAM_WIDTH), .LATENCY(READ_LATENCY)) u_pipe_b (
    .clk       (clk),
    .rst       (rst),
    .load      (ld_b_s),
    .data_in   (rd_b_s),
    .data_out  (pipe_data_b_s),
    .valid_out (pipe_valid_b_s)
  );

  // Collision rides the same pipeline so it lines up with the valid flags.
  blockram_out_pipe #(.WIDTH(32'd1), .LATENCY(READ_LATENCY)) u_pipe_coll (
    .clk       (clk),
    .rst       (rst),
    .load      (coll_s),
    .data_in   (coll_s),
    .data_out  (coll_data_s),
    .valid_out (coll_valid_s)
  );

  assign bus.data_out_A = pipe_data_a_s;
  assign bus.valid_A    = pipe_valid_a_s;
  assign bus.data_out_B = pipe_data_b_s;
  assign bus.valid_B    = pipe_valid_b_s;
  assign bus.collision  = coll_valid_s & coll_data_s;
  assign bus.busy       = busy_r;

endmodule

// File: tb/tb_blockram_true_dual_port.sv
// Self-checking bench: three RAM instances (different write modes / latencies)
// share one stimulus stream and are compared each cycle against an array model.
module tb_blockram_true_dual_port;
  import blockram_pkg::*;

  localparam int W    = 16;
  localparam int D    = 1024;
  localparam int NDUT = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        we_a, re_a, we_b, re_b;
  logic [1:0]  be_a, be_b;
  logic [9:0]  addr_a, addr_b;
  logic [15:0] din_a, din_b;

  blockram_true_dual_port_if #(.RAM_WIDTH(W), .RAM_DEPTH(D)) if0 ();
  blockram_true_dual_port_if #(.RAM_WIDTH(W), .RAM_DEPTH(D)) if1 ();
  blockram_true_dual_port_if #(.RAM_WIDTH(W), .RAM_DEPTH(D)) if2 ();

  assign if0.write_enable_A = we_a;   assign if1.write_enable_A = we_a;   assign if2.write_enable_A = we_a;
  assign if0.read_enable_A  = re_a;   assign if1.read_enable_A  = re_a;   assign if2.read_enable_A  = re_a;
  assign if0.byte_enable_A  = be_a;   assign if1.byte_enable_A  = be_a;   assign if2.byte_enable_A  = be_a;
  assign if0.address_A      = addr_a; assign if1.address_A      = addr_a; assign if2.address_A      = addr_a;
  assign if0.data_in_A      = din_a;  assign if1.data_in_A      = din_a;  assign if2.data_in_A      = din_a;
  assign if0.write_enable_B = we_b;   assign if1.write_enable_B = we_b;   assign if2.write_enable_B = we_b;
  assign if0.read_enable_B  = re_b;   assign if1.read_enable_B  = re_b;   assign if2.read_enable_B  = re_b;
  assign if0.byte_enable_B  = be_b;   assign if1.byte_enable_B  = be_b;   assign if2.byte_enable_B  = be_b;
  assign if0.address_B      = addr_b; assign if1.address_B      = addr_b; assign if2.address_B      = addr_b;
  assign if0.data_in_B      = din_b;  assign if1.data_in_B      = din_b;  assign if2.data_in_B      = din_b;

  blockram_true_dual_port #(.RAM_WIDTH(W), .RAM_DEPTH(D), .READ_LATENCY(1),
    .WRITE_MODE_A(READ_FIRST), .WRITE_MODE_B(WRITE_FIRST), .INIT_CLEAR(1'b1))
    dut0 (.clk(clk), .rst(rst), .bus(if0));
  blockram_true_dual_port #(.RAM_WIDTH(W), .RAM_DEPTH(D), .READ_LATENCY(2),
    .WRITE_MODE_A(WRITE_FIRST), .WRITE_MODE_B(NO_CHANGE), .INIT_CLEAR(1'b1))
    dut1 (.clk(clk), .rst(rst), .bus(if1));
  blockram_true_dual_port #(.RAM_WIDTH(W), .RAM_DEPTH(D), .READ_LATENCY(1),
    .WRITE_MODE_A(NO_CHANGE), .WRITE_MODE_B(READ_FIRST), .INIT_CLEAR(1'b1))
    dut2 (.clk(clk), .rst(rst), .bus(if2));

  logic [15:0] dout_a [NDUT];
  logic [15:0] dout_b [NDUT];
  logic        va [NDUT];
  logic        vb [NDUT];
  logic        coll [NDUT];
  logic        busy [NDUT];
  assign dout_a[0] = if0.data_out_A; assign dout_a[1] = if1.data_out_A; assign dout_a[2] = if2.data_out_A;
  assign dout_b[0] = if0.data_out_B; assign dout_b[1] = if1.data_out_B; assign dout_b[2] = if2.data_out_B;
  assign va[0] = if0.valid_A;   assign va[1] = if1.valid_A;   assign va[2] = if2.valid_A;
  assign vb[0] = if0.valid_B;   assign vb[1] = if1.valid_B;   assign vb[2] = if2.valid_B;
  assign coll[0] = if0.collision; assign coll[1] = if1.collision; assign coll[2] = if2.collision;
  assign busy[0] = if0.busy;    assign busy[1] = if1.busy;    assign busy[2] = if2.busy;

  // Model: word array, remaining clear cycles, and per-instance visible outputs.
  write_mode_t mode_a_m [NDUT];
  write_mode_t mode_b_m [NDUT];
  int          lat_m [NDUT];
  logic [15:0] mem_m [D];
  int          busy_left;
  logic [15:0] exp_da [NDUT];
  logic [15:0] exp_db [NDUT];
  logic        exp_va [NDUT];
  logic        exp_vb [NDUT];
  logic        exp_coll [NDUT];
  logic        exp_busy;
  logic [16:0] pend_a [NDUT];
  logic [16:0] pend_b [NDUT];
  logic        pend_c [NDUT];

  int  n_tests = 0;
  int  n_fail  = 0;
  bit  chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Response of one port for one accepted edge, as {valid, data}.
  function automatic logic [16:0] port_resp(input write_mode_t m, input logic we, input logic re,
                                            input logic [1:0] be, input logic [15:0] din,
                                            input logic [15:0] old);
    logic [15:0] merged;
    merged = old;
    if (be[0]) merged[7:0]  = din[7:0];
    if (be[1]) merged[15:8] = din[15:8];
    if (!(we || re)) return 17'd0;
    if (we && (m == NO_CHANGE)) return 17'd0;
    if (we && (m == WRITE_FIRST)) return {1'b1, merged};
    return {1'b1, old};
  endfunction

  task automatic show(input int i, input logic [16:0] ra, input logic [16:0] rb, input logic c);
    exp_va[i] = ra[16];
    if (ra[16]) exp_da[i] = ra[15:0];
    exp_vb[i] = rb[16];
    if (rb[16]) exp_db[i] = rb[15:0];
    exp_coll[i] = c;
  endtask

  task automatic model_edge();
    logic [15:0] old_a, old_b;
    logic [16:0] ra, rb;
    logic        c, acc;
    if (rst) begin
      busy_left = D;
      exp_busy  = 1'b1;
      for (int i = 0; i < NDUT; i++) begin
        exp_da[i] = 16'h0; exp_db[i] = 16'h0; exp_va[i] = 1'b0; exp_vb[i] = 1'b0;
        exp_coll[i] = 1'b0; pend_a[i] = 17'd0; pend_b[i] = 17'd0; pend_c[i] = 1'b0;
      end
    end else begin
      acc   = (busy_left == 0);
      old_a = mem_m[addr_a];
      old_b = mem_m[addr_b];
      c     = acc && we_a && we_b && (addr_a == addr_b);
      if (!acc) begin
        busy_left--;
        if (busy_left == 0) begin
          for (int k = 0; k < D; k++) mem_m[k] = 16'h0;
        end
      end else begin
        if (we_b && be_b[0]) mem_m[addr_b][7:0]  = din_b[7:0];
        if (we_b && be_b[1]) mem_m[addr_b][15:8] = din_b[15:8];
        if (we_a && be_a[0]) mem_m[addr_a][7:0]  = din_a[7:0];
        if (we_a && be_a[1]) mem_m[addr_a][15:8] = din_a[15:8];
      end
      for (int i = 0; i < NDUT; i++) begin
        ra = acc ? port_resp(mode_a_m[i], we_a, re_a, be_a, din_a, old_a) : 17'd0;
        rb = acc ? port_resp(mode_b_m[i], we_b, re_b, be_b, din_b, old_b) : 17'd0;
        if (lat_m[i] == 1) begin
          show(i, ra, rb, c);
        end else begin
          show(i, pend_a[i], pend_b[i], pend_c[i]);
          pend_a[i] = ra; pend_b[i] = rb; pend_c[i] = c;
        end
      end
      exp_busy = (busy_left != 0);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    we_a = 1'b0; re_a = 1'b0; be_a = 2'b00; addr_a = 10'd0; din_a = 16'h0;
    we_b = 1'b0; re_b = 1'b0; be_b = 2'b00; addr_b = 10'd0; din_b = 16'h0;
  endtask

  // Compare process: every output of every instance against the model, each cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int i = 0; i < NDUT; i++) begin
          check($sformatf("dut%0d data_out_A", i), 32'(dout_a[i]), 32'(exp_da[i]));
          check($sformatf("dut%0d valid_A", i),    32'(va[i]),     32'(exp_va[i]));
          check($sformatf("dut%0d data_out_B", i), 32'(dout_b[i]), 32'(exp_db[i]));
          check($sformatf("dut%0d valid_B", i),    32'(vb[i]),     32'(exp_vb[i]));
          check($sformatf("dut%0d collision", i),  32'(coll[i]),   32'(exp_coll[i]));
          check($sformatf("dut%0d busy", i),       32'(busy[i]),   32'(exp_busy));
        end
      end
    end
  end

  logic [15:0] seq_exp [4];

  initial begin
    mode_a_m[0] = READ_FIRST;  mode_b_m[0] = WRITE_FIRST; lat_m[0] = 1;
    mode_a_m[1] = WRITE_FIRST; mode_b_m[1] = NO_CHANGE;   lat_m[1] = 2;
    mode_a_m[2] = NO_CHANGE;   mode_b_m[2] = READ_FIRST;  lat_m[2] = 1;
    seq_exp[0] = 16'habcd; seq_exp[1] = 16'h1111; seq_exp[2] = 16'h2222; seq_exp[3] = 16'h3333;
    idle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk_en = 1'b1;
    check("busy after reset", 32'(if0.busy), 32'd1);
    check("data_out_A after reset", 32'(if0.data_out_A), 32'd0);

    // Requests during the clear sweep must be ignored.
    we_a = 1'b1; be_a = 2'b11; addr_a = 10'd9; din_a = 16'hdead; re_b = 1'b1; addr_b = 10'd9;
    repeat (10) cycle();
    idle();
    repeat (1013) cycle();
    check("busy last clear cycle", 32'(if1.busy), 32'd1);
    we_a = 1'b1; be_a = 2'b11; addr_a = 10'd0; din_a = 16'hffff;
    cycle();
    idle();
    check("busy released", 32'(if0.busy), 32'd0);
    check("model busy released", 32'(exp_busy), 32'd0);

    re_a = 1'b1; addr_a = 10'd1023; re_b = 1'b1; addr_b = 10'd0;
    cycle();
    idle();
    check("read 1023 data", 32'(if0.data_out_A), 32'd0);
    check("read 1023 valid", 32'(if0.valid_A), 32'd1);
    check("dropped write addr0", 32'(if2.data_out_B), 32'd0);
    check("dropped write addr0 valid", 32'(if2.valid_B), 32'd1);
    re_b = 1'b1; addr_b = 10'd9;
    cycle();
    idle();
    check("dropped write addr9", 32'(if2.data_out_B), 32'd0);

    we_a = 1'b1; be_a = 2'b11; addr_a = 10'd0; din_a = 16'habcd;
    cycle();
    idle();
    re_b = 1'b1; addr_b = 10'd0;
    cycle();
    idle();
    check("cross-port read abcd", 32'(if0.data_out_B), 32'h0000abcd);
    check("cross-port read valid", 32'(if0.valid_B), 32'd1);
    check("model cross-port read", 32'(exp_db[0]), 32'h0000abcd);
    cycle();
    check("lat2 cross-port read abcd", 32'(if1.data_out_B), 32'h0000abcd);

    we_a = 1'b1; be_a = 2'b11; addr_a = 10'd5; din_a = 16'h1234;
    cycle();
    we_a = 1'b1; be_a = 2'b10; addr_a = 10'd5; din_a = 16'hff00;
    cycle();
    idle();
    check("READ_FIRST old word", 32'(if0.data_out_A), 32'h00001234);
    check("READ_FIRST valid", 32'(if0.valid_A), 32'd1);
    check("NO_CHANGE hold", 32'(if2.data_out_A), 32'd0);
    check("NO_CHANGE no valid", 32'(if2.valid_A), 32'd0);
    cycle();
    check("WRITE_FIRST merged", 32'(if1.data_out_A), 32'h0000ff34);
    check("model WRITE_FIRST", 32'(exp_da[1]), 32'h0000ff34);
    re_b = 1'b1; addr_b = 10'd5;
    cycle();
    idle();
    check("array after lane write", 32'(if0.data_out_B), 32'h0000ff34);

    we_a = 1'b1; be_a = 2'b01; addr_a = 10'd7; din_a = 16'haaaa;
    we_b = 1'b1; be_b = 2'b11; addr_b = 10'd7; din_b = 16'hbbbb;
    cycle();
    idle();
    check("collision pulse", 32'(if0.collision), 32'd1);
    cycle();
    check("collision one cycle", 32'(if0.collision), 32'd0);
    check("lat2 collision", 32'(if1.collision), 32'd1);
    re_a = 1'b1; addr_a = 10'd7;
    cycle();
    we_a = 1'b1; be_a = 2'b00; addr_a = 10'd7; din_a = 16'h1111; re_a = 1'b0;
    check("collision merge", 32'(if0.data_out_A), 32'h0000bbaa);
    cycle();
    idle();
    check("empty-lane write valid", 32'(if0.valid_A), 32'd1);
    check("empty-lane write data", 32'(if0.data_out_A), 32'h0000bbaa);

    for (int k = 1; k < 4; k++) begin
      we_b = 1'b1; be_b = 2'b11; addr_b = 10'(k); din_b = 16'(k * 32'h1111);
      cycle();
    end
    idle();
    cycle();
    for (int k = 0; k < 5; k++) begin
      idle();
      if (k < 4) begin
        re_a = 1'b1; addr_a = 10'(k);
      end
      cycle();
      if (k > 0) begin
        check($sformatf("lat2 burst data %0d", k - 1), 32'(if1.data_out_A), 32'(seq_exp[k-1]));
        check($sformatf("lat2 burst valid %0d", k - 1), 32'(if1.valid_A), 32'd1);
      end
    end
    idle();
    cycle();
    check("lat2 burst end", 32'(if1.valid_A), 32'd0);

    we_a = 1'b1; be_a = 2'b11; addr_a = 10'd10; din_a = 16'h5a5a;
    cycle();
    we_a = 1'b0; re_a = 1'b1;
    cycle();
    idle();
    check("write then read", 32'(if2.data_out_A), 32'h00005a5a);

    for (int i = 0; i < 16; i++) begin
      we_a = i[0]; re_a = 1'b1; be_a = i[2:1]; addr_a = 10'(20 + i % 4); din_a = 16'(32'h1001 * i);
      we_b = i[1]; re_b = i[0]; be_b = i[3:2] | 2'b01; addr_b = 10'(20 + (i / 2) % 4);
      din_b = 16'(32'hf00f - 32'h0101 * i);
      cycle();
    end
    idle();
    repeat (3) cycle();

    rst = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (500) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    we_a = 1'b1; be_a = 2'b11; addr_a = 10'd0; din_a = 16'hbeef; re_b = 1'b1; addr_b = 10'd5;
    repeat (1023) cycle();
    check("busy after mid-clear reset", 32'(if0.busy), 32'd1);
    cycle();
    idle();
    check("busy done after restart", 32'(if0.busy), 32'd0);
    re_a = 1'b1; addr_a = 10'd0; re_b = 1'b1; addr_b = 10'd5;
    cycle();
    idle();
    check("cleared addr0", 32'(if0.data_out_A), 32'd0);
    check("cleared addr0 valid", 32'(if0.valid_A), 32'd1);
    check("cleared addr5", 32'(if2.data_out_B), 32'd0);
    repeat (3) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
